// File: rtl/instr_loader_pkg.sv
// Shared types and helpers for the boot-time instruction RAM loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } loader_state_e;

  localparam logic [3:0] LOADER_BE_ALL = '1;

  // Byte address of word idx past base, wrapped to an aw-bit byte address space.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx,
                                            input int          aw);
    logic [31:0] w;
    w = (base >> 2) + idx;
    w = w & ((32'd1 << (aw - 2)) - 32'd1);
    return w << 2;
  endfunction

endpackage

// File: rtl/instr_ram_loader_cnt.sv
// Word index counter with synchronous clear and a terminal-count flag (cnt == n).
module loader_cnt #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] n,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == n);

endmodule

// File: rtl/instr_ram_loader.sv
// Streams instruction words into the instruction RAM, optionally reads them back
// to check the additive checksum, then releases core fetch.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_LOAD   | accepting stream words, one RAM write per handshake
// ST_VERIFY | reading region back, accumulating readback sum, then compare
// ST_DONE   | image in place; fetch enabled unless checksum mismatched
module instr_ram_loader
  import instr_loader_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-2:0]   num_words_i,
  input  logic                    verify_i,
  input  logic                    data_valid_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    data_ready_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic                    fetch_en_o,
  output logic [DATA_WIDTH-1:0]   checksum_o
);

  loader_state_e         state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-2:0] num_q;
  logic                  verify_q;
  logic [DATA_WIDTH-1:0] checksum_q;
  logic [DATA_WIDTH-1:0] rb_sum_q;
  logic                  error_q;
  logic                  rsp_v_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_WIDTH-2:0] wr_idx;
  logic [ADDR_WIDTH-2:0] rd_idx;
  logic                  wr_tc;
  logic                  rd_tc;
  logic                  start_ok;
  logic                  wr_hs;
  logic                  wr_last;
  logic                  rd_issue;

  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // wr_tc guard keeps a runaway handshake from ever writing past N words
  assign wr_hs    = (state_q == ST_LOAD) && data_valid_i && !wr_tc;
  assign wr_last  = (wr_idx == num_q - 1'b1);
  assign rd_issue = (state_q == ST_VERIFY) && !rd_tc;

  loader_cnt #(.W(ADDR_WIDTH-1)) u_wr_cnt (
    .clk (clk),
    .rst (rst_i),
    .clr (start_ok),
    .inc (wr_hs),
    .n   (num_q),
    .cnt (wr_idx),
    .tc  (wr_tc)
  );

  loader_cnt #(.W(ADDR_WIDTH-1)) u_rd_cnt (
    .clk (clk),
    .rst (rst_i),
    .clr (start_ok),
    .inc (rd_issue),
    .n   (num_q),
    .cnt (rd_idx),
    .tc  (rd_tc)
  );

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (wr_hs) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_addr_o  = ADDR_WIDTH'(word_addr(32'(base_q), 32'(wr_idx), ADDR_WIDTH));
      ram_wdata_o = data_i;
    end else if (rd_issue) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = ADDR_WIDTH'(word_addr(32'(base_q), 32'(rd_idx), ADDR_WIDTH));
    end
  end

  assign ram_be_o     = ram_we_o ? LOADER_BE_ALL : '0;
  assign data_ready_o = (state_q == ST_LOAD);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      verify_q   <= 1'b0;
      checksum_q <= '0;
      rb_sum_q   <= '0;
      error_q    <= 1'b0;
      rsp_v_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rsp_v_q <= rd_issue;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            base_q     <= base_addr_i;
            num_q      <= num_words_i;
            verify_q   <= verify_i;
            checksum_q <= '0;
            rb_sum_q   <= '0;
            error_q    <= 1'b0;
            if (num_words_i == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (wr_hs) begin
            checksum_q <= checksum_q + data_i;
            if (wr_last) begin
              if (verify_q) begin
                state_q <= ST_VERIFY;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        ST_VERIFY: begin
          if (rsp_v_q) begin
            rb_sum_q <= rb_sum_q + ram_rdata_i;
          end
          // all reads issued and last response already summed: compare cycle
          if (rd_tc && !rsp_v_q) begin
            error_q <= (rb_sum_q != checksum_q);
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign fetch_en_o = done_q & ~error_q;
  assign checksum_o = checksum_q;

endmodule
